// File: rtl/mem_access_seq_if.sv
// ---------------------------------------------------------------------------
// mem_access_seq_if
// Request/response bus between the core's load/store stage and the memory
// access sequencer.
//   req_valid / req_ready : request handshake, transfer when both high
//   req_we                : 1 = store, 0 = load
//   req_funct3            : RV32 load/store funct3 (size and extension)
//   req_addr              : byte address
//   req_wdata             : store data, right-aligned
//   resp_valid            : one-cycle completion pulse
//   resp_rdata            : extended load data (0 for stores and errors)
//   resp_err              : unsupported funct3, qualified by resp_valid
// Modports: master = load/store stage, slave = sequencer.
// ---------------------------------------------------------------------------
interface mem_access_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_seq.sv
// ---------------------------------------------------------------------------
// mem_access_seq
// Sequencer between the load/store stage and a single-port synchronous data
// memory. Accepts one request at a time, selects byte lanes, splits accesses
// that straddle a word boundary into two aligned word accesses, and returns
// sign/zero-extended load data through a registered response.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus       : request/response bus (slave side)
//   mem_en    : memory access strobe
//   mem_we    : byte write enables, lane i = bits 8i+7:8i
//   mem_addr  : word address
//   mem_din   : write data
//   mem_dout  : read data, valid the cycle after mem_en
// ---------------------------------------------------------------------------
module mem_access_seq #(
    parameter int MEM_AWIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_access_seq_if.slave       bus,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [MEM_AWIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    typedef enum logic [2:0] {IDLE, FIRST, SECOND, CAPTURE, RESP} state_t;

    state_t      state;
    logic        is_store_q;
    logic        err_q;
    logic        split_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] st_hi_q;     // upper half of the shifted store data
    logic [3:0]  we_hi_q;     // upper half of the shifted byte mask
    logic [31:0] lo_word_q;   // first word of a split load
    logic        mem_en_q;
    logic [3:0]  mem_we_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    // Request decode, evaluated on the incoming request in IDLE.
    logic        req_err;
    logic        req_split;
    logic [2:0]  req_size;
    logic [3:0]  req_m4;
    logic [7:0]  req_mask;
    logic [63:0] req_data;
    logic [1:0]  req_off;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        req_off  = bus.req_addr[1:0];
        req_size = 3'd4;
        req_m4   = 4'b1111;
        case (bus.req_funct3[1:0])
            2'b00:   begin req_size = 3'd1; req_m4 = 4'b0001; end
            2'b01:   begin req_size = 3'd2; req_m4 = 4'b0011; end
            default: begin req_size = 3'd4; req_m4 = 4'b1111; end
        endcase
        if (bus.req_we)
            req_err = (bus.req_funct3 > 3'd2);
        else
            req_err = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
        // Offset (max 3) plus size (max 4) fits in 3 bits.
        req_split = (({1'b0, req_off} + req_size) > 3'd4);
        req_mask  = {4'b0000, req_m4} << req_off;
        req_data  = {32'b0, bus.req_wdata} << {req_off, 3'b000};
    end

    // Load assembly: {second, first} shifted down by the byte offset. For a
    // split load mem_dout is the second word; otherwise it is the only word.
    logic [63:0] load_pair;
    logic [31:0] load_word;
    logic [31:0] load_ext;

    always_comb begin
        load_pair = split_q ? {mem_dout, lo_word_q} : {32'b0, mem_dout};
        load_word = 32'(load_pair >> {off_q, 3'b000});
        case (f3_q)
            3'b000:  load_ext = {{24{load_word[7]}}, load_word[7:0]};
            3'b001:  load_ext = {{16{load_word[15]}}, load_word[15:0]};
            3'b010:  load_ext = load_word;
            3'b100:  load_ext = {24'b0, load_word[7:0]};
            3'b101:  load_ext = {16'b0, load_word[15:0]};
            default: load_ext = 32'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            is_store_q   <= 1'b0;
            err_q        <= 1'b0;
            split_q      <= 1'b0;
            f3_q         <= 3'b0;
            off_q        <= 2'b0;
            st_hi_q      <= 32'b0;
            we_hi_q      <= 4'b0;
            lo_word_q    <= 32'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0;
            mem_addr     <= '0;
            mem_din      <= 32'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
            resp_err_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below re-arms them.
            mem_en_q     <= 1'b0;
            mem_we_q     <= 4'b0;
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        is_store_q <= bus.req_we;
                        err_q      <= req_err;
                        split_q    <= req_split;
                        f3_q       <= bus.req_funct3;
                        off_q      <= req_off;
                        st_hi_q    <= req_data[63:32];
                        we_hi_q    <= req_mask[7:4];
                        // Errors also pass through FIRST, with the memory
                        // left idle, so their response lands at T+2.
                        state      <= FIRST;
                        if (!req_err) begin
                            mem_en_q <= 1'b1;
                            mem_addr <= bus.req_addr[MEM_AWIDTH+1:2];
                            mem_we_q <= bus.req_we ? req_mask[3:0] : 4'b0;
                            mem_din  <= bus.req_we ? req_data[31:0] : 32'b0;
                        end
                    end
                end
                FIRST: begin
                    if (err_q) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'b0;
                        state        <= RESP;
                    end else if (split_q) begin
                        mem_en_q <= 1'b1;
                        mem_addr <= mem_addr + MEM_AWIDTH'(1); // wraps at the top word
                        mem_we_q <= is_store_q ? we_hi_q : 4'b0;
                        mem_din  <= is_store_q ? st_hi_q : 32'b0;
                        state    <= SECOND;
                    end else if (is_store_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'b0;
                        state        <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                SECOND: begin
                    if (is_store_q) begin
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'b0;
                        state        <= RESP;
                    end else begin
                        lo_word_q <= mem_dout;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    resp_valid_q <= 1'b1;
                    resp_rdata_q <= load_ext;
                    resp_err_q   <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    resp_rdata_q <= 32'b0;
                    resp_err_q   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The strobes are masked by rst so that a reset arriving in SECOND
    // suppresses the upper half of a split store at the very edge it would
    // have been written.
    assign mem_en = mem_en_q & ~rst;
    assign mem_we = mem_we_q & {4{~rst}};

    assign bus.req_ready  = (state == IDLE) && !rst;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // Address bits above the memory range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[31:MEM_AWIDTH+2];

endmodule

// File: tb/tb_mem_access_seq.sv
// ---------------------------------------------------------------------------
// tb_mem_access_seq
// Scoreboard bench for mem_access_seq: the driver pushes expected responses
// and expected memory accesses into queues; a monitor compares them against
// what the DUT presents. Includes a behavioural synchronous memory.
// ---------------------------------------------------------------------------
module tb_mem_access_seq;

    localparam int AW = 14;

    logic          clk;
    logic          rst;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    mem_access_seq_if bus_if ();

    mem_access_seq #(.MEM_AWIDTH(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port memory; dout holds until the next access.
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'b0;
        mem[0]   = 32'h44332211;
        mem[1]   = 32'h88776655;
        mem_dout = 32'b0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_we[i]) mem[mem_addr][8*i +: 8] <= mem_din[8*i +: 8];
            mem_dout <= mem[mem_addr];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc_cyc;
        string       name;
    } resp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    we;
        logic [31:0]   din;
        string         name;
    } acc_t;

    resp_t exp_q[$];
    acc_t  acc_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every memory access and every response is popped and compared.
    always @(negedge clk) begin
        acc_t  a;
        resp_t r;
        if (mem_en) begin
            if (acc_q.size() == 0) begin
                fail_now($sformatf("unexpected access addr=%h we=%b", mem_addr, mem_we));
            end else begin
                a = acc_q.pop_front();
                check({a.name, " acc_addr"}, 32'(mem_addr), 32'(a.addr));
                check({a.name, " acc_we"}, 32'(mem_we), 32'(a.we));
                if (a.we != 4'b0) check({a.name, " acc_din"}, mem_din, a.din);
            end
        end else if (mem_we != 4'b0) begin
            fail_now($sformatf("mem_we=%b without mem_en", mem_we));
        end
        if (bus_if.resp_valid) begin
            if (exp_q.size() == 0) begin
                fail_now($sformatf("unexpected response rdata=%h", bus_if.resp_rdata));
            end else begin
                r = exp_q.pop_front();
                check({r.name, " rdata"}, bus_if.resp_rdata, r.rdata);
                check({r.name, " err"}, 32'(bus_if.resp_err), 32'(r.err));
                check({r.name, " latency"}, 32'(cyc - r.acc_cyc), 32'(r.lat));
            end
        end
    end

    task automatic push_acc(input string name, input logic [AW-1:0] addr,
                            input logic [3:0] we, input logic [31:0] din);
        acc_t a;
        a.addr = addr; a.we = we; a.din = din; a.name = name;
        acc_q.push_back(a);
    endtask

    // Waits (bounded) at a falling edge for req_ready, then drives the request.
    task automatic drive_req(input string name, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
        int k = 0;
        @(negedge clk);
        while (!bus_if.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus_if.req_ready) fail_now({name, " req_ready timeout"});
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
    endtask

    task automatic idle_inputs();
        bus_if.req_valid  = 1'b0;
        // Garbage on the unqualified request fields must be ignored.
        bus_if.req_we     = 1'b1;
        bus_if.req_funct3 = 3'b010;
        bus_if.req_addr   = 32'h0000_0005;
        bus_if.req_wdata  = 32'hFFFF_FFFF;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 && (exp_q.size() != 0 || acc_q.size() != 0); i++)
            @(negedge clk);
        if (exp_q.size() != 0 || acc_q.size() != 0) begin
            fail_now({name, " completion timeout"});
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    // One full transaction: nacc expected accesses (a0, then a1), one response.
    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input int nacc,
                         input logic [AW-1:0] a0, input logic [3:0] w0, input logic [31:0] d0,
                         input logic [AW-1:0] a1, input logic [3:0] w1, input logic [31:0] d1);
        resp_t r;
        drive_req(name, we, f3, addr, wdata);
        if (nacc > 0) push_acc(name, a0, w0, d0);
        if (nacc > 1) push_acc(name, a1, w1, d1);
        r.rdata = exp_rdata; r.err = exp_err; r.lat = lat; r.acc_cyc = cyc; r.name = name;
        exp_q.push_back(r);
        @(negedge clk);
        idle_inputs();
        wait_done(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus_if.req_ready), 32'd0);
        check("reset mem_en", 32'(mem_en), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_din", mem_din, 32'd0);
        check("reset resp_valid", 32'(bus_if.resp_valid), 32'd0);
        check("reset resp_rdata", bus_if.resp_rdata, 32'd0);
        check("reset resp_err", 32'(bus_if.resp_err), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("req_ready after reset", 32'(bus_if.req_ready), 32'd1);

        // Loads on the preloaded image.
        issue("LW@0",  1'b0, 3'b010, 32'h0, 32'hDEADBEEF, 32'h44332211, 1'b0, 3, 1, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LB@7",  1'b0, 3'b000, 32'h7, 32'hDEADBEEF, 32'hFFFFFF88, 1'b0, 3, 1, 14'd1, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LBU@7", 1'b0, 3'b100, 32'h7, 32'hDEADBEEF, 32'h00000088, 1'b0, 3, 1, 14'd1, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LH@3",  1'b0, 3'b001, 32'h3, 32'hDEADBEEF, 32'h00005544, 1'b0, 4, 2, 14'd0, 4'b0, 32'h0, 14'd1, 4'b0, 32'h0);
        issue("LW@2",  1'b0, 3'b010, 32'h2, 32'hDEADBEEF, 32'h66554433, 1'b0, 4, 2, 14'd0, 4'b0, 32'h0, 14'd1, 4'b0, 32'h0);
        issue("LHU@6", 1'b0, 3'b101, 32'h6, 32'hDEADBEEF, 32'h00008877, 1'b0, 3, 1, 14'd1, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LH@6",  1'b0, 3'b001, 32'h6, 32'hDEADBEEF, 32'hFFFF8877, 1'b0, 3, 1, 14'd1, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);

        // Split store across words 0/1.
        issue("SW@1",  1'b1, 3'b010, 32'h1, 32'hAABBCCDD, 32'h0, 1'b0, 3, 2,
              14'd0, 4'b1110, 32'hBBCCDD00, 14'd1, 4'b0001, 32'h000000AA);
        issue("LW@0 after SW", 1'b0, 3'b010, 32'h0, 32'h0, 32'hBBCCDD11, 1'b0, 3, 1, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LW@4 after SW", 1'b0, 3'b010, 32'h4, 32'h0, 32'h887766AA, 1'b0, 3, 1, 14'd1, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);

        // Split half-store at the last word wraps to word 0.
        issue("SH@FFFF", 1'b1, 3'b001, 32'h0000FFFF, 32'h00001234, 32'h0, 1'b0, 3, 2,
              14'h3FFF, 4'b1000, 32'h34000000, 14'd0, 4'b0001, 32'h00000012);
        issue("LBU@FFFF", 1'b0, 3'b100, 32'h0000FFFF, 32'h0, 32'h00000034, 1'b0, 3, 1, 14'h3FFF, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LB@0 after SH", 1'b0, 3'b000, 32'h0, 32'h0, 32'h00000012, 1'b0, 3, 1, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LW@FFFE wrap", 1'b0, 3'b010, 32'h0000FFFE, 32'h0, 32'hDD123400, 1'b0, 4, 2, 14'h3FFF, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);

        // Unsupported funct3: no memory access, error at T+2.
        issue("LD f3=011",  1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 2, 0, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("L f3=110",   1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 1'b1, 2, 0, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("S f3=011",   1'b1, 3'b011, 32'h0, 32'h5A5A5A5A, 32'h0, 1'b1, 2, 0, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("S f3=100",   1'b1, 3'b100, 32'h1, 32'h5A5A5A5A, 32'h0, 1'b1, 2, 0, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);

        // Split store interrupted by reset during SECOND: only the first half lands.
        drive_req("SW@1 rst", 1'b1, 3'b010, 32'h1, 32'h01020304);
        push_acc("SW@1 rst", 14'd0, 4'b1110, 32'h02030400);
        @(negedge clk);          // FIRST cycle
        idle_inputs();
        @(posedge clk);          // SECOND begins
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst mid req_ready", 32'(bus_if.req_ready), 32'd0);
        check("rst mid mem_en", 32'(mem_en), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post-rst req_ready", 32'(bus_if.req_ready), 32'd1);
        check("post-rst mem_addr", 32'(mem_addr), 32'd0);
        check("post-rst mem_din", mem_din, 32'd0);
        check("post-rst resp_valid", 32'(bus_if.resp_valid), 32'd0);
        repeat (4) @(negedge clk);
        check("rst mid pending accesses", 32'(acc_q.size()), 32'd0);
        acc_q.delete();
        issue("LW@0 after rst", 1'b0, 3'b010, 32'h0, 32'h0, 32'h02030412, 1'b0, 3, 1, 14'd0, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);
        issue("LW@4 after rst", 1'b0, 3'b010, 32'h4, 32'h0, 32'h887766AA, 1'b0, 3, 1, 14'd1, 4'b0, 32'h0, 14'd0, 4'b0, 32'h0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
